// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_pkg: shared register-file widths and writeback request types
package regfile_pkg;
   localparam int REG_AW = 5;
   localparam int REG_DW = 32;
   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [REG_DW-1:0] reg_data_t;
   typedef struct packed {
      reg_addr_t addr;
      reg_data_t data;
   } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: packed valid/ready writeback request bus from NUM_REQ sources plus stall
interface regfile_wb_arbiter_if
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int AW = REG_AW,
   parameter int DW = REG_DW
) ();
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*AW-1:0] req_addr;
   logic [NUM_REQ*DW-1:0] req_data;
   logic                  wb_stall;
   modport master (output req_valid, req_addr, req_data, wb_stall, input req_ready);
   modport slave (input req_valid, req_addr, req_data, wb_stall, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker, searching req upward from ptr with wraparound
module rr_arbiter #(
   parameter int N = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          any_gnt
);
   always_comb begin
      int j;
      j = 0;
      gnt = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (en && req[j] && !any_gnt) begin
            gnt[j] = 1'b1;
            gnt_idx = IW'(j);
            any_gnt = 1'b1;
         end
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port behind a one-entry write stage.
// Optional decode bypass ports when REGFILE_WB_BYPASS_EN is defined.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int AW = REG_AW,
   parameter int DW = REG_DW
) (
   input  logic                       clk,
   input  logic                       rst,
   regfile_wb_arbiter_if.slave        bus,
   output logic                       we3,
   output logic [AW-1:0]              waddr,
   output logic [DW-1:0]              wd3,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
`ifdef REGFILE_WB_BYPASS_EN
   ,
   input  logic [AW-1:0]              byp_rs1,
   input  logic [AW-1:0]              byp_rs2,
   output logic                       byp_hit1,
   output logic                       byp_hit2,
   output logic [DW-1:0]              byp_data
`endif
);
   localparam int IW = $clog2(NUM_REQ);
   logic [NUM_REQ-1:0] gnt;
   logic [IW-1:0]      gnt_idx, rr_ptr;
   logic               any_gnt, we_q;
   logic [AW-1:0]      g_addr;
   logic [DW-1:0]      g_data;
   rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
      .req(bus.req_valid),
      .ptr(rr_ptr),
      .en(!rst && !bus.wb_stall),
      .gnt(gnt),
      .gnt_idx(gnt_idx),
      .any_gnt(any_gnt)
   );
   assign bus.req_ready = gnt;
   assign g_addr = bus.req_addr[gnt_idx*AW +: AW];
   assign g_data = bus.req_data[gnt_idx*DW +: DW];
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q <= 1'b0;
         waddr <= '0;
         wd3 <= '0;
         grant_id <= '0;
         rr_ptr <= '0;
      end else begin
         we_q <= any_gnt && (g_addr != '0);
         if (any_gnt) begin
            waddr <= g_addr;
            wd3 <= g_data;
            grant_id <= gnt_idx;
            rr_ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
         end
      end
   end
   // an entry still in the stage when reset arrives must never reach the register file
   assign we3 = we_q && !rst;
`ifdef REGFILE_WB_BYPASS_EN
   assign byp_hit1 = we3 && (waddr == byp_rs1);
   assign byp_hit2 = we3 && (waddr == byp_rs2);
   assign byp_data = wd3;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized checks of the writeback arbiter against a
// behavioural model with its own register-file image.
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;
   localparam int N = 3;
   logic clk, rst;
   logic we3;
   logic [4:0] waddr;
   logic [31:0] wd3;
   logic [1:0] grant_id;
`ifdef REGFILE_WB_BYPASS_EN
   logic [4:0] byp_rs1, byp_rs2;
   logic byp_hit1, byp_hit2;
   logic [31:0] byp_data;
`endif
   regfile_wb_arbiter_if #(.NUM_REQ(N), .AW(5), .DW(32)) bus ();
   regfile_wb_arbiter #(.NUM_REQ(N), .AW(5), .DW(32)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave),
      .we3(we3),
      .waddr(waddr),
      .wd3(wd3),
      .grant_id(grant_id)
`ifdef REGFILE_WB_BYPASS_EN
      ,
      .byp_rs1(byp_rs1),
      .byp_rs2(byp_rs2),
      .byp_hit1(byp_hit1),
      .byp_hit2(byp_hit2),
      .byp_data(byp_data)
`endif
   );
   int tests, fails;
   logic [31:0] rf [32];
   logic [31:0] mrf [32];
   int mptr, m_gid, g_pre;
   bit m_we;
   logic [4:0] m_waddr, ga;
   logic [31:0] m_wd, gd;
   logic [N-1:0] obs_ready, exp_ready;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) if (we3) rf[waddr] <= wd3;
   function automatic logic [31:0] rd(logic [4:0] a);
      return (a == 5'd0) ? 32'd0 : rf[a];
   endfunction
   task automatic set_src(int i, logic v, logic [4:0] a, logic [31:0] d);
      bus.req_valid[i] = v;
      bus.req_addr[i*5 +: 5] = a;
      bus.req_data[i*32 +: 32] = d;
   endtask
   task automatic clear_srcs();
      for (int i = 0; i < N; i++) set_src(i, 1'b0, 5'd0, 32'd0);
   endtask
   // one clock: sample ready mid-cycle, predict the grant, then advance the model past the edge
   task automatic cycle();
      @(negedge clk);
      obs_ready = bus.req_ready;
      g_pre = -1;
      if (!rst && !bus.wb_stall)
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (mptr + k) % N;
            if (g_pre < 0 && bus.req_valid[idx]) g_pre = idx;
         end
      exp_ready = (g_pre < 0) ? '0 : N'(1 << g_pre);
      if (g_pre >= 0) begin
         ga = bus.req_addr[g_pre*5 +: 5];
         gd = bus.req_data[g_pre*32 +: 32];
      end
      @(posedge clk);
      if (rst) begin
         m_we = 0; m_waddr = '0; m_wd = '0; m_gid = 0; mptr = 0;
      end else begin
         if (m_we) mrf[m_waddr] = m_wd;
         m_we = (g_pre >= 0) && (ga != 5'd0);
         if (g_pre >= 0) begin
            m_waddr = ga; m_wd = gd; m_gid = g_pre; mptr = (g_pre + 1) % N;
         end
      end
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      clear_srcs();
      cycle();
      rst = 1'b0;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      clear_srcs();
      bus.wb_stall = 1'b0;
      set_src(0, 1'b1, 5'd3, 32'h1);
      cycle();
      tests++;
      if (obs_ready !== 3'b000) begin fails++; $display("FAIL reset_ready got=%b want=000", obs_ready); end
      cycle();
      rst = 1'b0;
      clear_srcs();
      tests++;
      if ({we3, waddr, wd3, grant_id} !== 40'd0)
         begin fails++; $display("FAIL reset_outputs got we3=%b waddr=%0d wd3=%h gid=%0d want all 0", we3, waddr, wd3, grant_id); end
   endtask
   task automatic test_reset_mid_write();
      set_src(1, 1'b1, 5'd7, 32'hDEADBEEF);
      cycle();
      tests++;
      if (obs_ready !== 3'b010) begin fails++; $display("FAIL rmid_grant got=%b want=010", obs_ready); end
      clear_srcs();
      rst = 1'b1;
      #1;
      tests++;
      if (we3 !== 1'b0) begin fails++; $display("FAIL rmid_we3 got=%b want=0", we3); end
      cycle();
      rst = 1'b0;
      tests++;
      if (rf[7] !== 32'd0) begin fails++; $display("FAIL rmid_nowrite got x7=%h want=0", rf[7]); end
      for (int i = 0; i < N; i++) set_src(i, 1'b1, 5'd20 + 5'(i), 32'h100 + i);
      cycle();
      tests++;
      if (obs_ready !== 3'b001) begin fails++; $display("FAIL rmid_ptr0 got=%b want=001", obs_ready); end
      clear_srcs();
      cycle();
   endtask
   task automatic test_single();
      set_src(0, 1'b1, 5'd5, 32'h12345678);
      cycle();
      tests++;
      if (obs_ready !== 3'b001) begin fails++; $display("FAIL single_ready got=%b want=001", obs_ready); end
      clear_srcs();
      tests++;
      if (we3 !== 1'b1 || waddr !== 5'd5 || wd3 !== 32'h12345678)
         begin fails++; $display("FAIL single_wb got we3=%b waddr=%0d wd3=%h want 1/5/12345678", we3, waddr, wd3); end
      cycle();
      tests++;
      if (rd(5'd5) !== 32'h12345678) begin fails++; $display("FAIL single_read got=%h want=12345678", rd(5'd5)); end
   endtask
   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < N; i++) set_src(i, 1'b1, 5'd1 + 5'(i), 32'hA0 + i);
      for (int c = 0; c < 6; c++) begin
         cycle();
         tests++;
         if (obs_ready !== N'(1 << (c % 3))) begin fails++; $display("FAIL rr_order c=%0d got=%b want=%b", c, obs_ready, N'(1 << (c % 3))); end
         tests++;
         if (grant_id !== 2'(c % 3)) begin fails++; $display("FAIL rr_gid c=%0d got=%0d want=%0d", c, grant_id, c % 3); end
      end
      clear_srcs();
      cycle();
   endtask
   task automatic test_x0();
      set_src(2, 1'b1, 5'd0, 32'hFFFFFFFF);
      cycle();
      tests++;
      if (obs_ready !== 3'b100) begin fails++; $display("FAIL x0_ready got=%b want=100", obs_ready); end
      clear_srcs();
      tests++;
      if (we3 !== 1'b0 || grant_id !== 2'd2) begin fails++; $display("FAIL x0_we3 got we3=%b gid=%0d want 0/2", we3, grant_id); end
      cycle();
      tests++;
      if (rf[0] !== 32'd0) begin fails++; $display("FAIL x0_read got=%h want=0", rf[0]); end
   endtask
   task automatic test_stall();
      set_src(0, 1'b1, 5'd11, 32'h0B0B0B0B);
      cycle();
      clear_srcs();
      bus.wb_stall = 1'b1;
      set_src(1, 1'b1, 5'd13, 32'h0D0D0D0D);
      tests++;
      if (we3 !== 1'b1 || waddr !== 5'd11) begin fails++; $display("FAIL stall_drain got we3=%b waddr=%0d want 1/11", we3, waddr); end
      for (int c = 0; c < 3; c++) begin
         cycle();
         tests++;
         if (obs_ready !== 3'b000 || we3 !== 1'b0)
            begin fails++; $display("FAIL stall_hold c=%0d got ready=%b we3=%b want 000/0", c, obs_ready, we3); end
      end
      bus.wb_stall = 1'b0;
      cycle();
      tests++;
      if (obs_ready !== 3'b010) begin fails++; $display("FAIL stall_release got=%b want=010", obs_ready); end
      clear_srcs();
      tests++;
      if (we3 !== 1'b1 || waddr !== 5'd13 || wd3 !== 32'h0D0D0D0D)
         begin fails++; $display("FAIL stall_write got we3=%b waddr=%0d wd3=%h want 1/13/0d0d0d0d", we3, waddr, wd3); end
      cycle();
      tests++;
      if (rd(5'd11) !== 32'h0B0B0B0B) begin fails++; $display("FAIL stall_x11 got=%h want=0b0b0b0b", rd(5'd11)); end
   endtask
   task automatic test_back_to_back();
      logic [31:0] later;
      set_src(0, 1'b1, 5'd12, 32'h0000AAAA);
      set_src(1, 1'b1, 5'd12, 32'h0000BBBB);
      cycle();
      set_src(obs_ready[0] ? 0 : 1, 1'b0, 5'd0, 32'd0);
      cycle();
      later = obs_ready[0] ? 32'h0000AAAA : 32'h0000BBBB;
      tests++;
      if (obs_ready === 3'b000) begin fails++; $display("FAIL b2b_second got=%b want one-hot", obs_ready); end
      clear_srcs();
      cycle();
      cycle();
      tests++;
      if (rd(5'd12) !== later) begin fails++; $display("FAIL b2b_order got=%h want=%h", rd(5'd12), later); end
   endtask
`ifdef REGFILE_WB_BYPASS_EN
   task automatic test_bypass();
      byp_rs1 = 5'd9;
      byp_rs2 = 5'd3;
      set_src(0, 1'b1, 5'd9, 32'hA5A5A5A5);
      cycle();
      clear_srcs();
      tests++;
      if (byp_hit1 !== 1'b1 || byp_hit2 !== 1'b0 || byp_data !== 32'hA5A5A5A5)
         begin fails++; $display("FAIL bypass got h1=%b h2=%b d=%h want 1/0/a5a5a5a5", byp_hit1, byp_hit2, byp_data); end
      cycle();
   endtask
`endif
   task automatic test_random();
      wb_req_t r;
      logic [4:0] a;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         cycle();
         tests++;
         if (obs_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, obs_ready, exp_ready); end
         tests++;
         if (we3 !== m_we || waddr !== m_waddr || wd3 !== m_wd || grant_id !== 2'(m_gid))
            begin fails++; $display("FAIL rnd_stage c=%0d got %b/%0d/%h/%0d want %b/%0d/%h/%0d", c, we3, waddr, wd3, grant_id, m_we, m_waddr, m_wd, m_gid); end
         a = 5'($urandom);
         tests++;
         if (rd(a) !== ((a == 5'd0) ? 32'd0 : mrf[a])) begin fails++; $display("FAIL rnd_rf c=%0d x%0d got=%h want=%h", c, a, rd(a), mrf[a]); end
         for (int i = 0; i < N; i++) begin
            if (obs_ready[i] || !bus.req_valid[i] || ($urandom_range(9) == 0)) begin
               r.addr = 5'($urandom);
               r.data = $urandom;
               set_src(i, 1'($urandom_range(1)), r.addr, r.data);
            end
         end
         bus.wb_stall = ($urandom_range(3) == 0);
      end
      bus.wb_stall = 1'b0;
      clear_srcs();
      cycle();
   endtask
   initial begin
      tests = 0;
      fails = 0;
      for (int i = 0; i < 32; i++) begin rf[i] = '0; mrf[i] = '0; end
      mptr = 0; m_gid = 0; m_we = 0; m_waddr = '0; m_wd = '0;
      rst = 1'b1;
      bus.wb_stall = 1'b0;
      clear_srcs();
`ifdef REGFILE_WB_BYPASS_EN
      byp_rs1 = '0;
      byp_rs2 = '0;
`endif
      test_reset();
      test_reset_mid_write();
      test_single();
      test_round_robin();
      test_x0();
      test_stall();
      test_back_to_back();
`ifdef REGFILE_WB_BYPASS_EN
      test_bypass();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NUM_REQ writeback sources (ALU, load unit, mul/div, ...).
- Each source offers a valid/ready write request. The block picks one source per cycle by round-robin and registers the winner into a one-entry write stage.
- The write stage drives the register file's we3/waddr/wd3 pins directly.
- Writes to x0 are accepted from the source but never issued to the register file.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- AW, 5, register address width.
- DW, 32, write data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-source write request valid.
- req_ready  out  NUM_REQ  per-source grant; the request is consumed when valid&ready.
- req_addr  in  NUM_REQ*AW  packed destination addresses; source i occupies bits [i*AW +: AW].
- req_data  in  NUM_REQ*DW  packed write data; source i occupies bits [i*DW +: DW].
- wb_stall  in  1  pipeline stall; blocks new grants.
- we3  out  1  register file write enable.
- waddr  out  AW  register file write address.
- wd3  out  DW  register file write data.
- grant_id  out  $clog2(NUM_REQ)  index of the source currently held in the write stage (debug/perf).

Behaviour:
- Reset, when rst is high at an edge:
  - we3=0, waddr=0, wd3=0, grant_id=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready combinationally 0 while rst is high.
  - A request in flight in the write stage is discarded and never written.
- Arbitration (combinational, same cycle):
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first valid index g wins: req_ready[g]=1, all other ready bits 0.
  - At most one ready bit is high per cycle.
  - Ready never depends on a source's own ready. Ready may depend on valid.
- No grant occurs when wb_stall=1 or no valid is asserted; all ready bits are 0.
- Source handshake:
  - A source holds valid, addr and data stable until it sees ready.
  - The arbiter makes no assumption beyond this; a source may drop valid without being granted.
- Pointer update: on a grant to g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Write stage, one-cycle latency:
  - A grant in cycle t loads the stage at the end of cycle t.
  - In cycle t+1: waddr=req_addr[g], wd3=req_data[g], grant_id=g.
  - we3 = (req_addr[g] != 0).
  - The register file commits at the end of cycle t+1.
- Write stage with no grant in cycle t: we3=0 in cycle t+1; waddr/wd3/grant_id hold their previous values.
- The write stage never back-pressures, because the register file accepts every cycle. Sustained throughput is one write per cycle.
- x0: a request with addr=0 is granted and consumed normally, but produces we3=0. It still advances rr_ptr.
- wb_stall:
  - Only suppresses new grants.
  - An entry already in the write stage is still issued in the following cycle. Stall never cancels a write.
- Fairness: with all NUM_REQ sources continuously valid, each is granted exactly once in every NUM_REQ consecutive non-stalled cycles.
- Same-address writes from different sources in consecutive grants issue in grant order; the later write wins.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- When defined, adds these ports:
  - byp_rs1 in AW, byp_rs2 in AW.
  - byp_hit1 out 1, byp_hit2 out 1.
  - byp_data out DW.
- byp_hitN = we3 && (waddr == byp_rsN), evaluated combinationally.
- byp_data = wd3.
- Decode uses the bypass to read a value that is being written in the current cycle. A hit on rs=0 is impossible because we3=0 for x0.
- When not defined, these ports and the logic behind them do not exist. Core behaviour is identical either way.

Decomposition:
- Package regfile_pkg:
  - REG_AW=5, REG_DW=32.
  - typedef reg_addr_t, reg_data_t.
  - typedef wb_req_t {reg_addr_t addr; reg_data_t data;}.
- Sub-module rr_arbiter, parameter N:
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot gnt, encoded gnt_idx, any_gnt.
  - Purely combinational.
- The pointer register, the write stage and the optional bypass stay in regfile_wb_arbiter.

Test Plan:
- Reset mid-write:
  - Grant source 1 (addr=7, data=0xDEADBEEF) and assert rst in the next cycle.
  - Required: we3=0 and no write; after reset, rr_ptr=0.
- Single source:
  - src0 valid, addr=5, data=0x12345678.
  - Required: ready[0]=1 in cycle t; we3=1, waddr=5, wd3=0x12345678 in t+1; reading x5 returns 0x12345678 in t+2.
- All three sources valid for 6 cycles, rr_ptr=0:
  - Required: grant order 0,1,2,0,1,2; grant_id follows one cycle later.
- x0 drop:
  - src2 valid with addr=0, data=0xFFFFFFFF.
  - Required: ready[2]=1; we3=0 next cycle; x0 still reads 0.
- Stall:
  - wb_stall=1 for 3 cycles with src1 valid.
  - Required: ready all 0 and we3=0 throughout.
  - Release: grant in the first unstalled cycle.
  - An entry granted just before the stall still writes in the first stall cycle.
- Bypass (with REGFILE_WB_BYPASS_EN):
  - Issue write addr=9, data=0xA5A5A5A5, with byp_rs1=9, byp_rs2=3.
  - Required: byp_hit1=1, byp_hit2=0, byp_data=0xA5A5A5A5 in the we3 cycle.
